// File: rtl/cdu_pip_pulse_conditioner.sv
// Purpose: synchronise raw CDU/PIPA/shaft/trunnion pulses and hold one signed pending-count accumulator per channel for the counter cell.
// Latency: a raw rising edge becomes a request after 3-4 clocks, and an ACK retires its count at the next edge.
// Backpressure: requests stay level-held until ACKed; counts beyond +/-(2^(ACC_W-1)-1) saturate and set a sticky OVF flag.
module cdu_pip_pulse_conditioner #(
    parameter int N_CH  = 8,
    parameter int ACC_W = 4
) (
    input  logic            CLOCK,
    input  logic            rst,
    input  logic [N_CH-1:0] RAW_P,
    input  logic [N_CH-1:0] RAW_M,
    input  logic [N_CH-1:0] CH_EN,
    input  logic [N_CH-1:0] ACK,
    input  logic            OVF_CLR,
    output logic [N_CH-1:0] REQ_P,
    output logic [N_CH-1:0] REQ_M,
    output logic [N_CH-1:0] OVF,
    output logic            BUSY
);

    localparam int SUM_W = ACC_W + 2;
    localparam logic signed [SUM_W-1:0] ONE     = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;

    logic [N_CH-1:0] s1_p, s2_p, s3_p;
    logic [N_CH-1:0] s1_m, s2_m, s3_m;
    logic [N_CH-1:0] edge_p, edge_m;
    logic [1:0]      warm_q;
    logic            armed;

    // The history flops restart at 0 after reset, so an input that is already high
    // looks like a fresh rising edge. Edges are therefore ignored until the whole
    // s1/s2/s3 chain has refilled from the live inputs.
    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            s1_p   <= '0;
            s2_p   <= '0;
            s3_p   <= '0;
            s1_m   <= '0;
            s2_m   <= '0;
            s3_m   <= '0;
            warm_q <= '0;
        end else begin
            s1_p <= RAW_P;
            s2_p <= s1_p;
            s3_p <= s2_p;
            s1_m <= RAW_M;
            s2_m <= s1_m;
            s3_m <= s2_m;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    assign armed  = (warm_q == 2'd3);
    assign edge_p = s2_p & ~s3_p;
    assign edge_m = s2_m & ~s3_m;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic signed [ACC_W-1:0] acc_q;
        logic signed [ACC_W-1:0] acc_d;
        logic signed [SUM_W-1:0] sum;
        logic                    inc, dec, req_p, req_m, ovf_q, ovf_hit;

        assign req_p = ~acc_q[ACC_W-1] & (|acc_q);
        assign req_m = acc_q[ACC_W-1];

        always_comb begin
            inc     = edge_p[i] & CH_EN[i] & armed;
            dec     = edge_m[i] & CH_EN[i] & armed;
            sum     = {{2{acc_q[ACC_W-1]}}, acc_q};
            ovf_hit = 1'b0;
            acc_d   = acc_q;
            if (inc) sum = sum + ONE;
            if (dec) sum = sum - ONE;
            if (ACK[i] && req_p) begin
                sum = sum - ONE;
            end else if (ACK[i] && req_m) begin
                sum = sum + ONE;
            end
            if (sum > ACC_MAX) begin
                acc_d   = ACC_MAX[ACC_W-1:0];
                ovf_hit = 1'b1;
            end else if (sum < ACC_MIN) begin
                acc_d   = ACC_MIN[ACC_W-1:0];
                ovf_hit = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end

        // A new saturation outranks a same-cycle clear.
        always_ff @(posedge CLOCK) begin
            if (!rst) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                acc_q <= acc_d;
                if (ovf_hit) begin
                    ovf_q <= 1'b1;
                end else if (OVF_CLR) begin
                    ovf_q <= 1'b0;
                end
            end
        end

        assign REQ_P[i] = req_p;
        assign REQ_M[i] = req_m;
        assign OVF[i]   = ovf_q;
    end

    assign BUSY = (|REQ_P) | (|REQ_M);

endmodule

// File: doc/cdu_pip_pulse_conditioner.md
Name: cdu_pip_pulse_conditioner

Overview:
- Input stage directly upstream of the counter-cell block.
- Takes raw asynchronous CDU/PIPA/shaft/trunnion pulse trains, synchronises and edge-detects them, and accumulates pending counts per channel in a signed up/down accumulator.
- Presents one level-held plus or minus request per channel (CDUXP/CDUXM-style) to the counter cell, and retires one count per acknowledge pulse returned by that cell.

Parameters:
- N_CH, 8, number of channels (0 CDUX, 1 CDUY, 2 CDUZ, 3 PIPX, 4 PIPY, 5 PIPZ, 6 SHAFT, 7 TRN).
- ACC_W, 4, signed accumulator width per channel; magnitude saturates at 2^(ACC_W-1)-1.

Ports:
- CLOCK  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- RAW_P  in  N_CH  asynchronous plus-pulse inputs, one per channel.
- RAW_M  in  N_CH  asynchronous minus-pulse inputs, one per channel.
- CH_EN  in  N_CH  per-channel enable; 0 = new edges ignored.
- ACK  in  N_CH  one-clock acknowledge from the counter cell: count serviced.
- OVF_CLR  in  1  clears all sticky overflow flags.
- REQ_P  out  N_CH  plus request (to CxxP inputs of the counter cell).
- REQ_M  out  N_CH  minus request (to CxxM inputs).
- OVF  out  N_CH  sticky saturation flag per channel.
- BUSY  out  1  OR of all REQ_P and REQ_M.

Behaviour:
- Reset: rst low at a rising edge clears all synchroniser flops, edge-history flops, accumulators and OVF.
  - REQ_P = REQ_M = OVF = 0 and BUSY = 0 from the following cycle.
  - Reset asserted mid-operation discards all pending counts. No request survives reset.
- Synchroniser: each RAW_P[i] and RAW_M[i] passes through two flops (s1, s2). A third history flop s3 supports edge detection.
  - Edge = s2 & ~s3, a rising-edge pulse exactly one clock wide.
  - Input pulses must stay high for at least 2 clocks and low for at least 2 clocks. Shorter pulses may be lost; this is not an error.
- Event per channel i, per cycle:
  - inc = edgeP & CH_EN[i]
  - dec = edgeM & CH_EN[i]
  - inc & dec cancel to net 0.
- Acknowledge:
  - ACK[i] with REQ_P[i]=1 gives -1.
  - ACK[i] with REQ_M[i]=1 gives +1.
  - ACK[i] with no request is ignored.
- Accumulator: acc_next = acc + (inc - dec) + ack_term, all applied in the same clock.
  - Net range per cycle is -2..+2.
  - Result clamps to ±(2^(ACC_W-1)-1); default ±7.
  - Any cycle in which clamping discards a nonzero part sets OVF[i]. OVF stays set until OVF_CLR or reset.
  - If OVF_CLR and a new overflow occur in the same cycle, set wins.
- Outputs, decoded from the accumulator flops with no extra combinational path from inputs:
  - REQ_P[i] = acc>0; REQ_M[i] = acc<0; never both.
  - BUSY is the combinational OR of all requests.
- Latency: RAW_P[i] rising before edge k gives s1 set at k, s2 at k+1, and an acc update at k+2. REQ_P is visible after edge k+2.
  - Minimum raw-to-request latency is 3 clocks; worst case is 4 clocks due to asynchronous sampling.
- Handshake: a request is level-held while acc≠0. Each ACK retires exactly one count.
  - The request drops in the cycle after the ACK that brings acc to 0.
  - ACK arriving in the same cycle as a new same-sign edge leaves acc unchanged and the request held.
- Sign crossing: when acc=+1, a dec edge together with an ACK gives -1, so REQ_M asserts the next cycle. This is legal and no count is lost.
- CH_EN low: the synchroniser still runs, so re-enabling does not create a spurious edge. Pending counts and ACK servicing continue.

Test Plan:
- Reset: rst=0 for 2 clocks while RAW_P=all 1 → REQ_P=REQ_M=OVF=0, BUSY=0. After release, no request from the already-high inputs (no rising edge).
- Latency and handshake: raw pulse on RAW_P[3] (3 clk high) → REQ_P[3]=1 3 to 4 clocks after rise. ACK[3] for one clock → REQ_P[3]=0 the next cycle, BUSY=0.
- Accumulation: 5 RAW_M[0] pulses, then 5 single ACK[0] pulses → REQ_M[0] stays high through 4 ACKs and drops after the 5th. No ACK is dropped or double-counted.
- Saturation: 9 RAW_P[6] pulses with no ACK → acc=+7 and OVF[6]=1. OVF_CLR → OVF[6]=0. Then 7 ACKs clear REQ_P[6].
- Simultaneous events:
  - RAW_P[1] and RAW_M[1] rising in the same clock → no request.
  - acc=+1 with ACK[1] plus a new RAW_M[1] edge in the same cycle → REQ_M[1]=1 next cycle.
  - acc=+2 with ACK[2] plus a RAW_P[2] edge → acc stays +2.
- Enable and mid-operation reset: CH_EN[4]=0 during 3 RAW_P[4] pulses → no request. With acc[5]=+3, assert rst for 1 clock → all requests 0. A subsequent ACK[5] has no effect.
